// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block: segment patterns, FSM states, digit count.
// Hex-letter patterns exist only when SEG7_HEX_EN is defined.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g} with a in the MSB
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

`ifdef SEG7_HEX_EN
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
`endif

  localparam logic [NUM_DIGITS-1:0] AN_NONE  = '1;
  localparam logic [6:0]            SEG_DARK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic [3:0] count_low(input logic [NUM_DIGITS-1:0] an);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cnt = cnt + {3'b000, ~an[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest active (low) anode; only meaningful when exactly one is low
  function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational 7-segment pattern to value decoder, shared with the display driver bench.
// SEG7_HEX_EN adds the A-F letter patterns; without it they decode as invalid.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_valid
);

  always_comb begin
    o_value = 4'h0;
    o_valid = 1'b1;
    case (i_pattern)
      SEG_0:   o_value = 4'h0;
      SEG_1:   o_value = 4'h1;
      SEG_2:   o_value = 4'h2;
      SEG_3:   o_value = 4'h3;
      SEG_4:   o_value = 4'h4;
      SEG_5:   o_value = 4'h5;
      SEG_6:   o_value = 4'h6;
      SEG_7:   o_value = 4'h7;
      SEG_8:   o_value = 4'h8;
      SEG_9:   o_value = 4'h9;
`ifdef SEG7_HEX_EN
      SEG_A:   o_value = 4'hA;
      SEG_B:   o_value = 4'hB;
      SEG_C:   o_value = 4'hC;
      SEG_D:   o_value = 4'hD;
      SEG_E:   o_value = 4'hE;
      SEG_F:   o_value = 4'hF;
`endif
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed 7-segment display: debounces each anode/segment sample, decodes
// committed digits and reports them through a valid/ready event port. Hex decode via SEG7_HEX_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_DIGITS-1:0]     an_in,
  input  logic [6:0]                seg_in,
  input  logic                      dp_in,
  input  logic                      clr,
  output logic [4*NUM_DIGITS-1:0]   digits_out,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [2:0]                upd_idx,
  output logic [3:0]                upd_val,
  output logic                      err_pattern,
  output logic                      err_multi_an,
  output logic                      err_ovf
);

  localparam logic [7:0] COUNT_HIT = 8'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_last_an;
  logic [6:0]              r_last_seg;
  logic                    r_last_dp;
  state_t                  r_state;
  state_t                  w_next_state;
  logic [7:0]              r_count;
  logic [7:0]              w_count_next;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_digit_valid;
  logic [NUM_DIGITS-1:0]   r_dp_out;
  logic                    r_upd_valid;
  logic [2:0]              r_upd_idx;
  logic [3:0]              r_upd_val;
  logic                    r_err_pattern;
  logic                    r_err_multi_an;
  logic                    r_err_ovf;

  logic [3:0]              w_low_cnt;
  logic                    w_single;
  logic                    w_multi;
  logic                    w_changed;
  logic [2:0]              w_idx;
  logic [3:0]              w_dec_value;
  logic                    w_dec_valid;
  logic                    w_count_hit;
  logic                    w_commit;
  logic                    w_write_digit;
  logic                    w_load_event;
  logic                    w_set_ovf;
  logic                    w_set_pattern;
  logic                    w_transfer;

  seg7_pattern_dec u_dec (
    .i_pattern (r_seg),
    .o_value   (w_dec_value),
    .o_valid   (w_dec_valid)
  );

  // Single input stage; idle (all dark) after reset so nothing looks like a digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_NONE;
      r_seg <= SEG_DARK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= an_in;
      r_seg <= seg_in;
      r_dp  <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_an  <= AN_NONE;
      r_last_seg <= SEG_DARK;
      r_last_dp  <= 1'b1;
    end else begin
      r_last_an  <= r_an;
      r_last_seg <= r_seg;
      r_last_dp  <= r_dp;
    end
  end

  assign w_low_cnt   = count_low(r_an);
  assign w_single    = (w_low_cnt == 4'd1);
  assign w_multi     = (w_low_cnt >= 4'd2);
  assign w_idx       = low_index(r_an);
  assign w_changed   = ({r_an, r_seg, r_dp} != {r_last_an, r_last_seg, r_last_dp});
  assign w_count_hit = (r_count == COUNT_HIT);
  assign w_transfer  = r_upd_valid && upd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!w_single) begin
      w_next_state = ST_IDLE;
    end else if (w_changed || (r_state == ST_IDLE)) begin
      w_next_state = ST_TRACK;
    end else if ((r_state == ST_TRACK) && w_count_hit) begin
      w_next_state = ST_HOLD;
    end
  end

  // HOLD keeps the count parked at STABLE_CYCLES, so a steady pattern cannot re-commit
  always_comb begin
    w_commit     = 1'b0;
    w_count_next = r_count;
    if (!w_single) begin
      w_count_next = '0;
    end else if (w_changed || (r_state == ST_IDLE)) begin
      w_count_next = 8'd1;
    end else if (r_state == ST_TRACK) begin
      w_count_next = r_count + 8'd1;
      w_commit     = w_count_hit;
    end
  end

  assign w_write_digit = w_commit && w_dec_valid;
  assign w_set_pattern = w_commit && !w_dec_valid;
  assign w_load_event  = w_write_digit && (!r_upd_valid || upd_ready);
  assign w_set_ovf     = w_write_digit && r_upd_valid && !upd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits      <= '0;
      r_digit_valid <= '0;
      r_dp_out      <= '0;
    end else if (w_write_digit) begin
      r_digits[{w_idx, 2'b00} +: 4] <= w_dec_value;
      r_digit_valid[w_idx]          <= 1'b1;
      r_dp_out[w_idx]               <= ~r_dp;
    end
  end

  // A fresh commit may replace the event that is leaving this same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_valid <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_val   <= '0;
    end else if (w_load_event) begin
      r_upd_valid <= 1'b1;
      r_upd_idx   <= w_idx;
      r_upd_val   <= w_dec_value;
    end else if (w_transfer) begin
      r_upd_valid <= 1'b0;
    end
  end

  // Setting a flag wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pattern  <= 1'b0;
      r_err_multi_an <= 1'b0;
      r_err_ovf      <= 1'b0;
    end else begin
      if (w_set_pattern)  r_err_pattern  <= 1'b1;
      else if (clr)       r_err_pattern  <= 1'b0;
      if (w_multi)        r_err_multi_an <= 1'b1;
      else if (clr)       r_err_multi_an <= 1'b0;
      if (w_set_ovf)      r_err_ovf      <= 1'b1;
      else if (clr)       r_err_ovf      <= 1'b0;
    end
  end

  assign digits_out   = r_digits;
  assign digit_valid  = r_digit_valid;
  assign dp_out       = r_dp_out;
  assign upd_valid    = r_upd_valid;
  assign upd_idx      = r_upd_idx;
  assign upd_val      = r_upd_val;
  assign err_pattern  = r_err_pattern;
  assign err_multi_an = r_err_multi_an;
  assign err_ovf      = r_err_ovf;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: directed display patterns, update events checked by a monitor.
// Expectations for the letter pattern follow SEG7_HEX_EN.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an_in;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic        clr;
  logic [31:0] digits_out;
  logic [7:0]  digit_valid;
  logic [7:0]  dp_out;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_val;
  logic        err_pattern;
  logic        err_multi_an;
  logic        err_ovf;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [6:0]  expQ[$];
  logic [6:0]  monExp;

  seg7_capture dut (
    .clk          (clk),
    .rst          (rst),
    .an_in        (an_in),
    .seg_in       (seg_in),
    .dp_in        (dp_in),
    .clr          (clr),
    .digits_out   (digits_out),
    .digit_valid  (digit_valid),
    .dp_out       (dp_out),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_idx      (upd_idx),
    .upd_val      (upd_val),
    .err_pattern  (err_pattern),
    .err_multi_an (err_multi_an),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg, input logic dp);
    an_in  = an;
    seg_in = seg;
    dp_in  = dp;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Each accepted handshake must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && upd_valid && upd_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL upd_event: got idx %0d val %0h, required no event", upd_idx, upd_val);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("upd_event", 32'({upd_idx, upd_val}), 32'(monExp));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    upd_ready = 1'b1;
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);
    checkOutput("reset_digits", digits_out, 32'h0);
    checkOutput("reset_valid", 32'(digit_valid), 32'h0);
    checkOutput("reset_flags", 32'({err_pattern, err_multi_an, err_ovf, upd_valid}), 32'h0);
    rst = 1'b0;
    tick(1);

    $display("[TB] digit 0 shows 2, commit on the fifth edge");
    applyStimulus(8'hFE, 7'b0010010, 1'b1);
    expQ.push_back({3'd0, 4'h2});
    tick(4);
    checkOutput("no_early_commit", 32'({digit_valid, 3'b000, upd_valid}), 32'h0);
    tick(1);
    checkOutput("commit_digit2", digits_out, 32'h2);
    checkOutput("commit_valid", 32'(digit_valid), 32'h01);
    checkOutput("commit_event", 32'({upd_valid, upd_idx, upd_val}), 32'({1'b1, 3'd0, 4'h2}));
    checkOutput("commit_dp", 32'(dp_out), 32'h0);
    tick(1);
    checkOutput("event_one_cycle", 32'(upd_valid), 32'h0);
    tick(10);
    checkOutput("hold_no_recommit", 32'({digit_valid, 3'b000, upd_valid}), 32'h010);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(3);

    $display("[TB] digit 3 shows 9 for too short a time");
    applyStimulus(8'hF7, 7'b0000100, 1'b1);
    tick(3);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(5);
    checkOutput("short_no_commit", 32'(digit_valid), 32'h01);
    checkOutput("short_no_flags", 32'({err_pattern, err_multi_an, err_ovf}), 32'h0);

    $display("[TB] digit 1 shows 1 with decimal point lit");
    applyStimulus(8'hFD, 7'b1001111, 1'b0);
    expQ.push_back({3'd1, 4'h1});
    tick(6);
    checkOutput("digit1_value", digits_out, 32'h12);
    checkOutput("digit1_dp", 32'(dp_out), 32'h02);
    checkOutput("digit1_valid", 32'(digit_valid), 32'h03);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);

    $display("[TB] two anodes low at once");
    applyStimulus(8'hFC, 7'h7F, 1'b1);
    tick(2);
    checkOutput("multi_set", 32'({err_multi_an, upd_valid}), 32'h2);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);
    checkOutput("multi_sticky", 32'(err_multi_an), 32'h1);
    pulseClr();
    checkOutput("multi_cleared", 32'(err_multi_an), 32'h0);
    applyStimulus(8'hFC, 7'h7F, 1'b1);
    tick(2);
    clr = 1'b1;
    tick(1);
    checkOutput("set_beats_clr", 32'(err_multi_an), 32'h1);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);
    clr = 1'b0;
    checkOutput("clr_after_idle", 32'(err_multi_an), 32'h0);

    $display("[TB] second commit while first event is stalled");
    upd_ready = 1'b0;
    applyStimulus(8'hFE, 7'b0000110, 1'b1);
    expQ.push_back({3'd0, 4'h3});
    tick(6);
    applyStimulus(8'hFD, 7'b0000000, 1'b1);
    tick(6);
    checkOutput("ovf_digits", 32'(digits_out[7:0]), 32'h83);
    checkOutput("ovf_flag", 32'(err_ovf), 32'h1);
    checkOutput("ovf_pending", 32'({upd_valid, upd_idx, upd_val}), 32'({1'b1, 3'd0, 4'h3}));
    upd_ready = 1'b1;
    tick(1);
    checkOutput("ovf_drained", 32'(upd_valid), 32'h0);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);
    pulseClr();
    checkOutput("flags_clear", 32'({err_pattern, err_multi_an, err_ovf}), 32'h0);

    $display("[TB] letter A pattern on digit 0");
    applyStimulus(8'hFE, 7'b0001000, 1'b1);
`ifdef SEG7_HEX_EN
    expQ.push_back({3'd0, 4'hA});
    tick(6);
    checkOutput("hex_value", 32'(digits_out[3:0]), 32'hA);
    checkOutput("hex_no_err", 32'(err_pattern), 32'h0);
`else
    tick(6);
    checkOutput("letter_err", 32'(err_pattern), 32'h1);
    checkOutput("letter_keeps", 32'({digit_valid, digits_out[7:0]}), 32'h0383);
    checkOutput("letter_no_event", 32'(upd_valid), 32'h0);
`endif
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);
    pulseClr();

    $display("[TB] commit coinciding with handshake");
    upd_ready = 1'b0;
    applyStimulus(8'hFB, 7'b0100100, 1'b1);
    expQ.push_back({3'd2, 4'h5});
    tick(6);
    applyStimulus(8'hF7, 7'b0001111, 1'b1);
    expQ.push_back({3'd3, 4'h7});
    tick(4);
    checkOutput("stalled_event", 32'({upd_valid, upd_idx, upd_val}), 32'({1'b1, 3'd2, 4'h5}));
    upd_ready = 1'b1;
    tick(1);
    checkOutput("reload_event", 32'({upd_valid, upd_idx, upd_val}), 32'({1'b1, 3'd3, 4'h7}));
    checkOutput("reload_no_ovf", 32'(err_ovf), 32'h0);
    checkOutput("reload_digit3", 32'(digits_out[15:12]), 32'h7);
    tick(1);
    checkOutput("reload_drained", 32'(upd_valid), 32'h0);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(2);

    $display("[TB] reset in the middle of tracking");
    applyStimulus(8'hFE, 7'b0100000, 1'b1);
    tick(3);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_digits", digits_out, 32'h0);
    checkOutput("async_reset_rest",
                32'({digit_valid, dp_out, upd_valid, upd_idx, upd_val, err_pattern, err_multi_an, err_ovf}),
                32'h0);
    tick(1);
    rst = 1'b0;
    expQ.push_back({3'd0, 4'h6});
    tick(4);
    checkOutput("post_reset_wait", 32'(digit_valid), 32'h0);
    tick(1);
    checkOutput("post_reset_commit", 32'({digit_valid, digits_out[3:0]}), 32'h016);
    checkOutput("post_reset_event", 32'(upd_valid), 32'h1);
    tick(1);
    applyStimulus(8'hFF, 7'h7F, 1'b1);
    tick(3);

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
